uart_prog_loader: RTL and testbench

Boot-time program loader between the UART receiver (`serialc`) and the data-memory write port. It holds the core in reset and waits for DRAM calibration. It then assembles incoming UART bytes into little-endian 32-bit words and writes them to consecutive word addresses through a one-entry buffered request/ack port. After `MEM_WORDS` words it releases the core. It replaces the ad-hoc byte/word/address counters currently scattered around the memory-init path with a single sequenced controller.

---
 rtl/loader_pkg.sv | 16 +
 rtl/word_assembler.sv | 35 +++
 rtl/uart_prog_loader.sv | 168 ++++++++++++++++
 tb/tb_uart_prog_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Optional feature macro used by the loader: LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        WAIT_CAL = 3'd0,
        LOAD     = 3'd1,
        CSUM     = 3'd2,
        DONE     = 3'd3,
        ERR      = 3'd4
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTECNT_W      = 2;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler. The completed word and its
// o_word_v pulse are presented in the same cycle as the 4th byte strobe,
// so the caller can register the word without an extra cycle of latency.
module word_assembler
    import loader_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    input  logic        i_we,
    output logic [31:0] o_word,
    output logic        o_word_v
);

    logic [31:0]          asm_q;
    logic [BYTECNT_W-1:0] bytecnt_q;
    logic                 take;

    assign take     = i_en & i_we;
    assign o_word   = {i_byte, asm_q[31:8]};
    assign o_word_v = take && (bytecnt_q == BYTECNT_W'(BYTES_PER_WORD - 1));

    // Shift accepted bytes in from the top; the 2-bit counter wraps after a word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            asm_q     <= 32'h0;
            bytecnt_q <= '0;
        end else if (take) begin
            asm_q     <= {i_byte, asm_q[31:8]};
            bytecnt_q <= bytecnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot-time program loader: gates on DRAM calibration, assembles UART bytes
// into words, writes them through a one-entry buffered req/ack port, then
// releases the core. Define LOADER_CHECKSUM_EN to require a trailing
// checksum word (sum of all data words, mod 2^32) before release.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int          MEM_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h0
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_calib,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_we,
    output logic        o_wreq,
    output logic [31:0] o_waddr,
    output logic [31:0] o_wdata,
    input  logic        i_wack,
    output logic        o_core_rst,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_word_cnt
);

    loader_state_t state_q, state_d;

    logic        wbuf_v_q;
    logic [31:0] wbuf_q;
    logic [31:0] waddr_q;
    logic [31:0] word_cnt_q;
    logic [31:0] in_cnt_q;     // data words accepted into the buffer
    logic        all_in_q;     // every data word has been accepted
    logic        core_rst_q;
    logic        done_q;
    logic        err_q;

    logic        asm_en;
    logic [31:0] asm_word;
    logic        asm_v;
    logic        ack_fire;
    logic        last_ack;
    logic        load_word;
    logic        overflow;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;
    logic        csum_seen_q;  // checksum matched before the last data ack
    logic        csum_ok;
    logic        csum_bad;
`endif

    word_assembler u_asm (
        .CLK      (CLK),
        .RST      (RST),
        .i_en     (asm_en),
        .i_byte   (i_rx_data),
        .i_we     (i_rx_we),
        .o_word   (asm_word),
        .o_word_v (asm_v)
    );

    // Transfer, completion and overflow conditions for the current cycle.
    always_comb begin
        ack_fire  = wbuf_v_q & i_wack;
        last_ack  = ack_fire && (word_cnt_q == 32'(MEM_WORDS - 1));
        load_word = asm_v && (state_q == LOAD) && !all_in_q && (!wbuf_v_q || i_wack);
        overflow  = asm_v && (state_q == LOAD) && !all_in_q && wbuf_v_q && !i_wack;
`ifdef LOADER_CHECKSUM_EN
        // Once all data words are in, the assembler is collecting the checksum.
        asm_en    = (state_q == LOAD) || (state_q == CSUM);
        csum_ok   = asm_v && all_in_q && (asm_word == sum_q);
        csum_bad  = asm_v && all_in_q && (asm_word != sum_q);
`else
        asm_en    = (state_q == LOAD) && !all_in_q;
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_CAL: if (i_calib) state_d = LOAD;
            LOAD: begin
                if (overflow) begin
                    state_d = ERR;
`ifdef LOADER_CHECKSUM_EN
                end else if (csum_bad) begin
                    state_d = ERR;
                end else if (last_ack) begin
                    state_d = (csum_seen_q || csum_ok) ? DONE : CSUM;
`else
                end else if (last_ack) begin
                    state_d = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (csum_ok)       state_d = DONE;
                else if (csum_bad) state_d = ERR;
            end
`endif
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= WAIT_CAL;
        else     state_q <= state_d;
    end

    // Write buffer, address/count registers and registered status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wbuf_v_q   <= 1'b0;
            wbuf_q     <= 32'h0;
            waddr_q    <= BASE_ADDR;
            word_cnt_q <= 32'h0;
            in_cnt_q   <= 32'h0;
            all_in_q   <= 1'b0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            core_rst_q <= (state_d != DONE);
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == ERR);
            if (load_word) begin
                wbuf_q   <= asm_word;
                wbuf_v_q <= 1'b1;
                in_cnt_q <= in_cnt_q + 32'd1;
                if (in_cnt_q == 32'(MEM_WORDS - 1)) all_in_q <= 1'b1;
            end else if (ack_fire) begin
                wbuf_v_q <= 1'b0;
            end
            if (ack_fire) begin
                word_cnt_q <= word_cnt_q + 32'd1;
                waddr_q    <= waddr_q + 32'd4;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum of every word accepted for writing, plus early-match flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sum_q       <= 32'h0;
            csum_seen_q <= 1'b0;
        end else begin
            if (load_word) sum_q <= sum_q + asm_word;
            if ((state_q == LOAD) && csum_ok) csum_seen_q <= 1'b1;
        end
    end
`endif

    assign o_wreq     = wbuf_v_q;
    assign o_wdata    = wbuf_q;
    assign o_waddr    = waddr_q;
    assign o_word_cnt = word_cnt_q;
    assign o_core_rst = core_rst_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader with a transaction-level model.
// Honours LOADER_CHECKSUM_EN when it is defined for the build.
module tb_uart_prog_loader;

    localparam int          MW   = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        i_calib = 1'b0;
    logic [7:0]  i_rx_data = 8'h0;
    logic        i_rx_we = 1'b0;
    logic        i_wack = 1'b0;
    logic        o_wreq, o_core_rst, o_done, o_err;
    logic [31:0] o_waddr, o_wdata, o_word_cnt;

    uart_prog_loader #(.MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_calib    (i_calib),
        .i_rx_data  (i_rx_data),
        .i_rx_we    (i_rx_we),
        .o_wreq     (o_wreq),
        .o_waddr    (o_waddr),
        .o_wdata    (o_wdata),
        .i_wack     (i_wack),
        .o_core_rst (o_core_rst),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_word_cnt (o_word_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t exp_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    // Model: the load as a sequence of words, tracked by counts and flags.
    logic        m_loading, m_pending, m_err, m_done, m_csum_ok;
    int unsigned m_written, m_accepted;
    logic [31:0] m_sum;
    logic [7:0]  m_bytes[$];
    logic [7:0]  m_cbytes[$];
    logic        cal_lvl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] q[$]);
        return {q[3], q[2], q[1], q[0]};
    endfunction

    task automatic model_reset();
        m_loading = 0; m_pending = 0; m_err = 0; m_done = 0; m_csum_ok = 0;
        m_written = 0; m_accepted = 0; m_sum = 0;
        m_bytes.delete(); m_cbytes.delete(); exp_q.delete();
    endtask

    task automatic model_step(input logic we, input logic [7:0] b, input logic wk, input logic cal);
        logic        ack;
        logic        reload;
        logic [31:0] w;
        ack    = m_pending && wk;
        reload = 1'b0;
        if (ack) m_written++;
        if (m_loading && !m_err && !m_done && we) begin
            if (m_accepted < MW) begin
                m_bytes.push_back(b);
                if (m_bytes.size() == 4) begin
                    w = pack4(m_bytes);
                    m_bytes.delete();
                    if (m_pending && !ack) begin
                        m_err = 1'b1;
                    end else begin
                        exp_q.push_back('{a: BASE + 32'(4 * m_accepted), d: w});
                        m_sum = m_sum + w;
                        m_accepted++;
                        reload = 1'b1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            else begin
                m_cbytes.push_back(b);
                if (m_cbytes.size() == 4) begin
                    w = pack4(m_cbytes);
                    m_cbytes.delete();
                    if (w == m_sum) m_csum_ok = 1'b1;
                    else            m_err = 1'b1;
                end
            end
`endif
        end
        if (reload)   m_pending = 1'b1;
        else if (ack) m_pending = 1'b0;
        if (!m_loading && cal) m_loading = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        m_done = !m_err && (m_written == MW) && m_csum_ok;
`else
        m_done = (m_written == MW);
`endif
    endtask

    task automatic cyc(input logic we, input logic [7:0] b, input logic wk);
        i_rx_we = we; i_rx_data = b; i_wack = wk; i_calib = cal_lvl;
        model_step(we, b, wk, cal_lvl);
        @(posedge CLK); #1;
        chk("wreq",     32'(o_wreq),     32'(m_pending));
        chk("waddr",    o_waddr,         BASE + 32'(4 * m_written));
        chk("word_cnt", o_word_cnt,      32'(m_written));
        chk("done",     32'(o_done),     32'(m_done));
        chk("err",      32'(o_err),      32'(m_err));
        chk("core_rst", 32'(o_core_rst), 32'(!m_done));
    endtask

    task automatic idle(input int n, input logic wk);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, wk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic wk);
        for (int i = 0; i < 4; i++) cyc(1'b1, w[8*i +: 8], wk);
    endtask

    task automatic do_reset();
        RST = 1'b1; i_rx_we = 0; i_wack = 0; i_calib = 0; cal_lvl = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_wreq",     32'(o_wreq),     32'd0);
        chk("rst_waddr",    o_waddr,         BASE);
        chk("rst_wdata",    o_wdata,         32'd0);
        chk("rst_core_rst", 32'(o_core_rst), 32'd1);
        chk("rst_done",     32'(o_done),     32'd0);
        chk("rst_err",      32'(o_err),      32'd0);
        chk("rst_word_cnt", o_word_cnt,      32'd0);
        RST = 1'b0;
    endtask

    // Monitor: every accepted transfer must match the next expected write.
    always @(negedge CLK) begin
        if (!RST && o_wreq) begin
            chk("wreq_expected", 32'(exp_q.size() != 0), 32'd1);
            if (i_wack && exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", o_waddr, e.a);
                chk("wr_data", o_wdata, e.d);
            end
        end
    end

    initial begin
        // Calibration gate: early bytes and the calib-edge byte are discarded.
        do_reset();
        cyc(1'b1, 8'h11, 1'b1);
        cyc(1'b1, 8'h22, 1'b1);
        idle(2, 1'b1);
        cal_lvl = 1'b1;
        cyc(1'b1, 8'hAA, 1'b1);
        send_word(32'h12345678, 1'b1);
        idle(3, 1'b1);
        chk("cal_sb_drain", 32'(exp_q.size()), 32'd0);
        chk("cal_one_write", o_word_cnt, 32'd1);

        // Full load with continuous ack, then trailing bytes are ignored.
        do_reset();
        cal_lvl = 1'b1;
        idle(1, 1'b1);
        for (int k = 0; k < MW; k++) begin
            send_word($urandom, 1'b1);
            idle(int'($urandom_range(0, 2)), 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(m_sum, 1'b1);
`endif
        idle(3, 1'b1);
        send_word($urandom, 1'b1);
        idle(2, 1'b1);
        chk("full_sb_drain", 32'(exp_q.size()), 32'd0);
        chk("full_done", 32'(o_done), 32'd1);

        // Backpressure overflow: second word completes with no ack.
        do_reset();
        cal_lvl = 1'b1;
        idle(1, 1'b0);
        send_word(32'hCAFE0001, 1'b0);
        idle(2, 1'b0);
        send_word(32'hCAFE0002, 1'b0);
        chk("bp_err", 32'(o_err), 32'd1);
        idle(2, 1'b1);
        send_word(32'hCAFE0003, 1'b1);
        idle(3, 1'b1);
        chk("bp_sb_drain", 32'(exp_q.size()), 32'd0);
        chk("bp_core_rst", 32'(o_core_rst), 32'd1);

        // Ack arrives in the same cycle the next word completes.
        do_reset();
        cal_lvl = 1'b1;
        idle(1, 1'b0);
        send_word(32'hA1B2C3D4, 1'b0);
        idle(2, 1'b0);
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        cyc(1'b1, 8'h03, 1'b0);
        cyc(1'b1, 8'h04, 1'b1);
        chk("same_wreq", 32'(o_wreq), 32'd1);
        chk("same_wdata", o_wdata, 32'h04030201);
        idle(3, 1'b1);
        chk("same_err", 32'(o_err), 32'd0);
        chk("same_sb_drain", 32'(exp_q.size()), 32'd0);

        // Reset mid-load, then a fresh full load from BASE.
        do_reset();
        cal_lvl = 1'b1;
        idle(1, 1'b1);
        send_word($urandom, 1'b1);
        send_word($urandom, 1'b1);
        idle(2, 1'b1);
        chk("mid_cnt", o_word_cnt, 32'd2);
        do_reset();
        cal_lvl = 1'b1;
        idle(1, 1'b1);
        for (int k = 0; k < MW; k++) send_word($urandom, 1'b1);
        idle(3, 1'b1);
        chk("fresh_sb_drain", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            cal_lvl = 1'b1;
            idle(1, 1'b1);
            for (int k = 1; k <= 4; k++) send_word(32'(k), 1'b1);
            idle(2, 1'b1);
            send_word((r == 0) ? 32'd10 : 32'd11, 1'b1);
            idle(2, 1'b1);
            chk("csum_done", 32'(o_done), (r == 0) ? 32'd1 : 32'd0);
            chk("csum_err", 32'(o_err), (r == 0) ? 32'd0 : 32'd1);
        end
`endif

        // Randomized runs: random strobes, acks, calib timing and calib drops.
        for (int it = 0; it < 10; it++) begin
            do_reset();
            for (int c = 0; c < int'($urandom_range(0, 3)); c++)
                cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
            cal_lvl = 1'b1;
            for (int c = 0; c < 60; c++) begin
                if (c > 5 && $urandom_range(0, 9) == 0) cal_lvl = ~cal_lvl;
                cyc(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 9) < 6));
            end
            idle(5, 1'b1);
            chk("rand_sb_drain", 32'(exp_q.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
